reg_write_initiator: RTL

Byte-stream-to-register-bank write master for the button-control path. Parses 5-byte command frames (header plus 32-bit big-endian payload) from an upstream byte source, such as a UART receiver or a test host. Issues each frame as one `we`/`wr_addr`/`wr_data` write into the control register bank and completes the `done` handshake before accepting the next frame. Malformed frames, writes to the system-owned register 0, and (optionally) an unresponsive bank are reported as error pulses.

---
 rtl/reg_write_initiator.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/reg_write_initiator.sv
// Parses 5-byte command frames (sync header + 32-bit big-endian payload) into register-bank writes.
// Optional `REG_WR_TIMEOUT_EN` bounds each wait for `done` to TIMEOUT_CYCLES cycles.
module reg_write_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        we,
  output logic [1:0]  wr_addr,
  output logic [31:0] wr_data,
  input  logic        done,
  output logic        busy,
  output logic        wr_ack,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned CODE_W = 2;
  localparam int unsigned BCNT_W = 2;

  localparam logic [5:0]        SYNC      = 6'b101010;
  localparam logic [CODE_W-1:0] ERR_HDR   = 2'b01;
  localparam logic [CODE_W-1:0] ERR_ADDR0 = 2'b10;
  localparam logic [BCNT_W-1:0] LAST_BYTE = 2'd3;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("reg_write_initiator: TIMEOUT_CYCLES must be in 2..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_WRITE,
    ST_RELEASE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic                rx_ready_d, we_d, busy_d, wr_ack_d, err_d;
  logic [ADDR_W-1:0]   wr_addr_d;
  logic [DATA_W-1:0]   wr_data_d;
  logic [CODE_W-1:0]   err_code_d;
  logic                accept;

`ifdef REG_WR_TIMEOUT_EN
  localparam int unsigned       TCNT_W  = 8;
  localparam logic [CODE_W-1:0] ERR_TMO = 2'b11;
  localparam logic [TCNT_W-1:0] TMO_LIM = TCNT_W'(TIMEOUT_CYCLES - 1);
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
`endif

  assign accept = rx_valid & rx_ready;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      acc_q    <= '0;
      bcnt_q   <= '0;
      rx_ready <= 1'b0;
      we       <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      wr_ack   <= 1'b0;
      err      <= 1'b0;
      err_code <= '0;
`ifdef REG_WR_TIMEOUT_EN
      tcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      acc_q    <= acc_d;
      bcnt_q   <= bcnt_d;
      rx_ready <= rx_ready_d;
      we       <= we_d;
      wr_addr  <= wr_addr_d;
      wr_data  <= wr_data_d;
      busy     <= busy_d;
      wr_ack   <= wr_ack_d;
      err      <= err_d;
      err_code <= err_code_d;
`ifdef REG_WR_TIMEOUT_EN
      tcnt_q   <= tcnt_d;
`endif
    end
  end

  // Next state and next output values
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    acc_d      = acc_q;
    bcnt_d     = bcnt_q;
    we_d       = we;
    wr_addr_d  = wr_addr;
    wr_data_d  = wr_data;
    wr_ack_d   = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code;
`ifdef REG_WR_TIMEOUT_EN
    tcnt_d     = tcnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (rx_data[7:2] != SYNC) begin
            err_d      = 1'b1;
            err_code_d = ERR_HDR;
          end else begin
            addr_d  = rx_data[ADDR_W-1:0];
            bcnt_d  = '0;
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (accept) begin
          acc_d  = {acc_q[DATA_W-BYTE_W-1:0], rx_data};
          bcnt_d = BCNT_W'(bcnt_q + 2'd1);
          if (bcnt_q == LAST_BYTE) begin
            // Register 0 is system-owned: consume the frame but never write it
            if (addr_q == '0) begin
              err_d      = 1'b1;
              err_code_d = ERR_ADDR0;
              state_d    = ST_IDLE;
            end else begin
              we_d      = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = {acc_q[DATA_W-BYTE_W-1:0], rx_data};
              state_d   = ST_WRITE;
`ifdef REG_WR_TIMEOUT_EN
              tcnt_d    = '0;
`endif
            end
          end
        end
      end

      ST_WRITE: begin
        if (done) begin
          we_d     = 1'b0;
          wr_ack_d = 1'b1;
          state_d  = ST_RELEASE;
`ifdef REG_WR_TIMEOUT_EN
          tcnt_d   = '0;
        end else if (tcnt_q == TMO_LIM) begin
          we_d       = 1'b0;
          err_d      = 1'b1;
          err_code_d = ERR_TMO;
          state_d    = ST_IDLE;
        end else begin
          tcnt_d = TCNT_W'(tcnt_q + 8'd1);
`endif
        end
      end

      ST_RELEASE: begin
        if (!done) begin
          state_d = ST_IDLE;
`ifdef REG_WR_TIMEOUT_EN
        end else if (tcnt_q == TMO_LIM) begin
          err_d      = 1'b1;
          err_code_d = ERR_TMO;
          state_d    = ST_IDLE;
        end else begin
          tcnt_d = TCNT_W'(tcnt_q + 8'd1);
`endif
        end
      end

      default: begin
        we_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // Handshake and status follow the state being entered so they stay aligned with it
    rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_DATA);
    busy_d     = (state_d != ST_IDLE);
  end

endmodule
